// File: rtl/csi_stream_monitor.sv
// CSI video-stream health monitor on the byte-clock domain.
// Measures line/frame geometry, frame rate and protocol sanity from the
// in_frame / in_line / dat_vld taps, and drives a registered debug bus.
module csi_stream_monitor #(
    parameter int WORDS_PER_LINE  = 480,
    parameter int LINES_PER_FRAME = 1080,
    parameter int CNT_W           = 16,
    parameter int FPS_W           = 8,
    parameter int LOCK_FRAMES     = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_frame,
    input  logic             in_line,
    input  logic             dat_vld,
    input  logic             sec_tick,
    input  logic             clr_err,
    input  logic [1:0]       dbg_sel,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] last_line_cnt,
    output logic [CNT_W-1:0] last_word_cnt,
    output logic [FPS_W-1:0] fps,
    output logic             err_line_len,
    output logic             err_frame_len,
    output logic             err_proto,
    output logic             locked,
    output logic [7:0]       debug_pins
);

    localparam logic [CNT_W-1:0]   CNT_MAX   = '1;
    localparam logic [FPS_W-1:0]   FPS_MAX   = '1;
    localparam logic [CNT_W-1:0]   WPL_N     = CNT_W'(WORDS_PER_LINE);
    localparam logic [CNT_W-1:0]   LPF_N     = CNT_W'(LINES_PER_FRAME);
    localparam int                 CLEAN_W   = (LOCK_FRAMES < 2) ? 1 : $clog2(LOCK_FRAMES + 1);
    localparam logic [CLEAN_W-1:0] LOCK_N    = CLEAN_W'(LOCK_FRAMES);
    localparam int                 FPS_DBG_W = (FPS_W < 8) ? FPS_W : 8;
    localparam int                 CNT_DBG_W = (CNT_W < 8) ? CNT_W : 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FRAME,
        S_LINE
    } state_t;

    state_t state, state_nxt;

    logic               frame_d, line_d;
    logic               frame_rise, frame_fall, line_rise, line_fall;
    logic               frame_start, frame_end, line_start, line_end;
    logic               proto_evt, line_bad, frame_len_bad, frame_bad;
    logic [CNT_W-1:0]   word_ctr, line_ctr, words_done, lines_done;
    logic [FPS_W-1:0]   sec_ctr, sec_sum;
    logic [CLEAN_W-1:0] clean_ctr, clean_nxt;

    assign frame_rise = in_frame & ~frame_d;
    assign frame_fall = ~in_frame & frame_d;
    assign line_rise  = in_line & ~line_d;
    assign line_fall  = ~in_line & line_d;

    // Next-state decode and per-cycle frame/line boundary strobes
    always_comb begin
        state_nxt   = state;
        frame_start = 1'b0;
        frame_end   = 1'b0;
        line_start  = 1'b0;
        line_end    = 1'b0;
        case (state)
            S_IDLE: begin
                if (frame_rise) begin
                    state_nxt   = S_FRAME;
                    frame_start = 1'b1;
                end
            end
            S_FRAME: begin
                if (frame_fall) begin
                    state_nxt = S_IDLE;
                    frame_end = 1'b1;
                end else if (line_rise) begin
                    state_nxt  = S_LINE;
                    line_start = 1'b1;
                end
            end
            S_LINE: begin
                // A frame fall inside a line closes the line first, then the frame.
                if (frame_fall) begin
                    state_nxt = S_IDLE;
                    line_end  = 1'b1;
                    frame_end = 1'b1;
                end else if (line_fall) begin
                    state_nxt = S_FRAME;
                    line_end  = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Derived counts including this cycle's word/line, plus error and lock decisions
    always_comb begin
        words_done    = (dat_vld && word_ctr != CNT_MAX) ? word_ctr + 1'b1 : word_ctr;
        lines_done    = (line_end && line_ctr != CNT_MAX) ? line_ctr + 1'b1 : line_ctr;
        sec_sum       = (frame_end && sec_ctr != FPS_MAX) ? sec_ctr + 1'b1 : sec_ctr;
        proto_evt     = (dat_vld && state != S_LINE) || (line_rise && state == S_IDLE);
        line_bad      = line_end && (words_done != WPL_N);
        frame_len_bad = frame_end && (lines_done != LPF_N);
        clean_nxt     = clean_ctr;
        if (frame_end) begin
            if (frame_bad || line_bad || frame_len_bad) begin
                clean_nxt = '0;
            end else if (clean_ctr != LOCK_N) begin
                clean_nxt = clean_ctr + 1'b1;
            end
        end
        if (line_bad || proto_evt) begin
            clean_nxt = '0;
        end
    end

    // FSM state and one-cycle-delayed input copies for edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            frame_d <= 1'b0;
            line_d  <= 1'b0;
        end else begin
            state   <= state_nxt;
            frame_d <= in_frame;
            line_d  <= in_line;
        end
    end

    // Geometry counters, results, sticky errors, fps and lock tracking
    always_ff @(posedge clk) begin
        if (reset) begin
            word_ctr      <= '0;
            line_ctr      <= '0;
            frame_bad     <= 1'b0;
            frame_cnt     <= '0;
            last_line_cnt <= '0;
            last_word_cnt <= '0;
            sec_ctr       <= '0;
            fps           <= '0;
            clean_ctr     <= '0;
            locked        <= 1'b0;
            err_line_len  <= 1'b0;
            err_frame_len <= 1'b0;
            err_proto     <= 1'b0;
        end else begin
            if (line_start) begin
                word_ctr <= '0;
            end else if (state == S_LINE) begin
                word_ctr <= words_done;
            end
            if (frame_start) begin
                line_ctr  <= '0;
                frame_bad <= 1'b0;
            end else begin
                if (line_end) begin
                    line_ctr <= lines_done;
                end
                if (line_bad) begin
                    frame_bad <= 1'b1;
                end
            end
            if (line_end) begin
                last_word_cnt <= words_done;
            end
            if (frame_end) begin
                last_line_cnt <= lines_done;
                frame_cnt     <= frame_cnt + 1'b1;
            end
            if (sec_tick) begin
                fps     <= sec_sum;
                sec_ctr <= '0;
            end else begin
                sec_ctr <= sec_sum;
            end
            clean_ctr     <= clean_nxt;
            locked        <= (clean_nxt == LOCK_N);
            err_line_len  <= line_bad | (err_line_len & ~clr_err);
            err_frame_len <= frame_len_bad | (err_frame_len & ~clr_err);
            err_proto     <= proto_evt | (err_proto & ~clr_err);
        end
    end

    // Registered debug bus, source chosen by dbg_sel
    always_ff @(posedge clk) begin
        if (reset) begin
            debug_pins <= '0;
        end else begin
            case (dbg_sel)
                2'd0:    debug_pins <= {locked, err_proto, err_frame_len, err_line_len,
                                        in_frame, in_line, dat_vld, sec_tick};
                2'd1:    debug_pins <= 8'(frame_cnt[CNT_DBG_W-1:0]);
                2'd2:    debug_pins <= 8'(fps[FPS_DBG_W-1:0]);
                default: debug_pins <= 8'(last_word_cnt[CNT_DBG_W-1:0]);
            endcase
        end
    end

endmodule

// File: tb/tb_csi_stream_monitor.sv
// Self-checking bench for csi_stream_monitor with a transaction-level model:
// frames and lines are generated as word/line counts and the expected results
// are computed from those counts when each line or frame completes.
module tb_csi_stream_monitor;

    localparam int WPL   = 4;
    localparam int LPF   = 3;
    localparam int CNT_W = 16;
    localparam int FPS_W = 8;
    localparam int LOCK  = 2;

    logic             clk = 1'b0;
    logic             reset, in_frame, in_line, dat_vld, sec_tick, clr_err;
    logic [1:0]       dbg_sel;
    logic [CNT_W-1:0] frame_cnt, last_line_cnt, last_word_cnt;
    logic [FPS_W-1:0] fps;
    logic             err_line_len, err_frame_len, err_proto, locked;
    logic [7:0]       debug_pins;

    csi_stream_monitor #(
        .WORDS_PER_LINE (WPL),
        .LINES_PER_FRAME(LPF),
        .CNT_W          (CNT_W),
        .FPS_W          (FPS_W),
        .LOCK_FRAMES    (LOCK)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_frame     (in_frame),
        .in_line      (in_line),
        .dat_vld      (dat_vld),
        .sec_tick     (sec_tick),
        .clr_err      (clr_err),
        .dbg_sel      (dbg_sel),
        .frame_cnt    (frame_cnt),
        .last_line_cnt(last_line_cnt),
        .last_word_cnt(last_word_cnt),
        .fps          (fps),
        .err_line_len (err_line_len),
        .err_frame_len(err_frame_len),
        .err_proto    (err_proto),
        .locked       (locked),
        .debug_pins   (debug_pins)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int m_frame_cnt, m_last_line, m_last_word, m_fps, m_sec, m_clean, m_lines;
    bit m_el, m_ef, m_ep, m_bad;
    bit pend_tick, pend_clr;

    task automatic model_reset();
        m_frame_cnt = 0; m_last_line = 0; m_last_word = 0; m_fps = 0; m_sec = 0;
        m_clean = 0; m_lines = 0; m_el = 0; m_ef = 0; m_ep = 0; m_bad = 0;
    endtask

    // One clock of stimulus; inputs change after a negedge, results seen at the next negedge
    task automatic cyc(input logic f, input logic l, input logic v);
        in_frame = f; in_line = l; dat_vld = v; sec_tick = pend_tick; clr_err = pend_clr;
        @(negedge clk);
        if (pend_clr && !reset) begin m_el = 0; m_ef = 0; m_ep = 0; end
        if (pend_tick && !reset) begin m_fps = (m_sec > 255) ? 255 : m_sec; m_sec = 0; end
        pend_tick = 0; pend_clr = 0; sec_tick = 0; clr_err = 0;
    endtask

    // A line of n words; when last, the final word arrives with in_frame and in_line falling together
    task automatic send_line(input int n, input bit last, input bit tick);
        int nw;
        nw = last ? n - 1 : n;
        cyc(1, 1, 0);
        for (int w = 0; w < nw; w++) begin
            repeat ($urandom_range(0, 2)) cyc(1, 1, 0);
            cyc(1, 1, 1);
        end
        repeat ($urandom_range(0, 1)) cyc(1, 1, 0);
        if (last) begin
            pend_tick = tick;
            cyc(0, 0, 1);
        end else begin
            cyc(1, 0, 0);
        end
        m_last_word = n;
        m_lines++;
        if (n != WPL) begin m_el = 1; m_bad = 1; m_clean = 0; end
    endtask

    // A frame of nl lines of WPL words, except line short_line which carries short_n words
    task automatic send_frame(input int nl, input int short_line, input int short_n,
                              input bit combined, input bit tick);
        bit last;
        m_lines = 0; m_bad = 0;
        cyc(1, 0, 0);
        repeat ($urandom_range(0, 1)) cyc(1, 0, 0);
        for (int i = 0; i < nl; i++) begin
            last = combined && (i == nl - 1);
            if (last) m_sec++;
            send_line((i == short_line) ? short_n : WPL, last, last && tick);
            if (!last) repeat ($urandom_range(0, 1)) cyc(1, 0, 0);
        end
        if (!(combined && nl > 0)) begin
            m_sec++;
            pend_tick = tick;
            cyc(0, 0, 0);
        end
        m_frame_cnt++;
        m_last_line = m_lines;
        if (m_lines != LPF) begin m_ef = 1; m_bad = 1; end
        m_clean = m_bad ? 0 : ((m_clean < LOCK) ? m_clean + 1 : m_clean);
    endtask

    task automatic test_reset();
        reset = 1;
        repeat (3) begin
            in_frame = 1'($urandom); in_line = 1'($urandom); dat_vld = 1'($urandom);
            sec_tick = 1'($urandom); clr_err = 1'($urandom); dbg_sel = 2'($urandom);
            @(negedge clk);
        end
        model_reset();
        checks++; if (frame_cnt !== '0) begin errors++; $display("FAIL reset.frame_cnt got=%0d exp=0", frame_cnt); end
        checks++; if (last_line_cnt !== '0 || last_word_cnt !== '0) begin errors++; $display("FAIL reset.last_cnts got=%0d/%0d exp=0/0", last_line_cnt, last_word_cnt); end
        checks++; if (fps !== '0) begin errors++; $display("FAIL reset.fps got=%0d exp=0", fps); end
        checks++; if ({err_line_len, err_frame_len, err_proto, locked} !== 4'b0) begin errors++; $display("FAIL reset.flags got=%b exp=0000", {err_line_len, err_frame_len, err_proto, locked}); end
        checks++; if (debug_pins !== 8'h00) begin errors++; $display("FAIL reset.debug_pins got=%h exp=00", debug_pins); end
        dbg_sel = 2'd0;
        reset = 0;
        cyc(0, 0, 0);
    endtask

    task automatic test_good_stream();
        send_frame(LPF, -1, 0, 0, 0);
        checks++; if (frame_cnt !== 16'd1 || locked !== 1'b0) begin errors++; $display("FAIL good.first got frame_cnt=%0d locked=%b exp 1/0", frame_cnt, locked); end
        send_frame(LPF, -1, 0, 0, 0);
        checks++; if (frame_cnt !== 16'd2) begin errors++; $display("FAIL good.frame_cnt got=%0d exp=2", frame_cnt); end
        checks++; if (last_line_cnt !== 16'd3 || last_word_cnt !== 16'd4) begin errors++; $display("FAIL good.geometry got=%0d/%0d exp=3/4", last_line_cnt, last_word_cnt); end
        checks++; if ({err_line_len, err_frame_len, err_proto} !== 3'b000) begin errors++; $display("FAIL good.errors got=%b exp=000", {err_line_len, err_frame_len, err_proto}); end
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL good.locked got=%b exp=1", locked); end
    endtask

    task automatic test_short_line();
        send_frame(LPF, 1, 3, 0, 0);
        checks++; if (err_line_len !== 1'b1 || locked !== 1'b0) begin errors++; $display("FAIL short.detect got err=%b locked=%b exp 1/0", err_line_len, locked); end
        checks++; if (err_frame_len !== 1'b0 || frame_cnt !== 16'(m_frame_cnt)) begin errors++; $display("FAIL short.frame got ef=%b cnt=%0d exp 0/%0d", err_frame_len, frame_cnt, m_frame_cnt); end
        pend_clr = 1;
        cyc(0, 0, 0);
        checks++; if (err_line_len !== 1'b0) begin errors++; $display("FAIL short.clear got=%b exp=0", err_line_len); end
        send_frame(LPF, -1, 0, 0, 0);
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL short.relock1 got=%b exp=0", locked); end
        send_frame(LPF, -1, 0, 0, 0);
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL short.relock2 got=%b exp=1", locked); end
    endtask

    task automatic test_protocol();
        cyc(1, 0, 0);
        cyc(1, 0, 1);
        m_ep = 1; m_clean = 0;
        checks++; if (err_proto !== 1'b1 || locked !== 1'b0) begin errors++; $display("FAIL proto.detect got ep=%b locked=%b exp 1/0", err_proto, locked); end
        pend_clr = 1;
        cyc(1, 0, 1);
        m_ep = 1;
        checks++; if (err_proto !== 1'b1) begin errors++; $display("FAIL proto.set_wins got=%b exp=1", err_proto); end
        m_sec++;
        cyc(0, 0, 0);
        m_frame_cnt++; m_last_line = 0; m_ef = 1; m_clean = 0;
        checks++; if (err_frame_len !== 1'b1 || last_line_cnt !== 16'd0) begin errors++; $display("FAIL proto.empty_frame got ef=%b lines=%0d exp 1/0", err_frame_len, last_line_cnt); end
        pend_clr = 1;
        cyc(0, 0, 0);
        checks++; if ({err_proto, err_frame_len, err_line_len} !== 3'b000) begin errors++; $display("FAIL proto.clear got=%b exp=000", {err_proto, err_frame_len, err_line_len}); end
        cyc(0, 1, 0);
        m_ep = 1;
        cyc(0, 0, 0);
        checks++; if (err_proto !== 1'b1 || last_word_cnt !== 16'(m_last_word)) begin errors++; $display("FAIL proto.idle_line got ep=%b words=%0d exp 1/%0d", err_proto, last_word_cnt, m_last_word); end
        pend_clr = 1;
        cyc(0, 0, 0);
    endtask

    task automatic test_combined_fall();
        send_frame(LPF, -1, 0, 1, 0);
        checks++; if (last_word_cnt !== 16'd4 || last_line_cnt !== 16'd3) begin errors++; $display("FAIL combined.geometry got=%0d/%0d exp=4/3", last_word_cnt, last_line_cnt); end
        checks++; if ({err_line_len, err_frame_len, err_proto} !== 3'b000) begin errors++; $display("FAIL combined.errors got=%b exp=000", {err_line_len, err_frame_len, err_proto}); end
        checks++; if (locked !== (m_clean >= LOCK)) begin errors++; $display("FAIL combined.locked got=%b exp=%b", locked, m_clean >= LOCK); end
    endtask

    task automatic test_fps();
        pend_tick = 1;
        cyc(0, 0, 0);
        checks++; if (fps !== 8'(m_fps)) begin errors++; $display("FAIL fps.first got=%0d exp=%0d", fps, m_fps); end
        repeat (5) send_frame(LPF, -1, 0, 0, 0);
        send_frame(LPF, -1, 0, 0, 1);
        checks++; if (fps !== 8'd6 || m_fps != 6) begin errors++; $display("FAIL fps.six got=%0d exp=6 (model %0d)", fps, m_fps); end
        pend_tick = 1;
        cyc(0, 0, 0);
        checks++; if (fps !== 8'd0) begin errors++; $display("FAIL fps.zero got=%0d exp=0", fps); end
    endtask

    task automatic test_debug();
        logic [7:0] exp;
        dbg_sel = 2'd0;
        pend_tick = 1;
        cyc(0, 0, 0);
        exp = {m_clean >= LOCK, m_ep, m_ef, m_el, 4'b0001};
        checks++; if (debug_pins !== exp) begin errors++; $display("FAIL debug.sel0 got=%h exp=%h", debug_pins, exp); end
        for (int s = 1; s < 4; s++) begin
            dbg_sel = 2'(s);
            cyc(0, 0, 0);
            exp = (s == 1) ? 8'(m_frame_cnt) : (s == 2) ? 8'(m_fps) : 8'(m_last_word);
            checks++; if (debug_pins !== exp) begin errors++; $display("FAIL debug.sel%0d got=%h exp=%h", s, debug_pins, exp); end
        end
        dbg_sel = 2'd0;
    endtask

    task automatic test_random();
        int nl, sl, sn;
        bit comb, tick;
        for (int k = 0; k < 16; k++) begin
            nl   = ($urandom_range(0, 3) == 0) ? $urandom_range(2, 4) : LPF;
            sl   = ($urandom_range(0, 2) == 0) ? $urandom_range(0, nl - 1) : -1;
            sn   = $urandom_range(1, 6);
            comb = 1'($urandom);
            tick = ($urandom_range(0, 3) == 0);
            pend_clr = ($urandom_range(0, 2) == 0);
            send_frame(nl, sl, sn, comb, tick);
            checks++; if (frame_cnt !== 16'(m_frame_cnt) || last_line_cnt !== 16'(m_last_line) || last_word_cnt !== 16'(m_last_word)) begin
                errors++; $display("FAIL rand%0d.counts got=%0d/%0d/%0d exp=%0d/%0d/%0d", k, frame_cnt, last_line_cnt, last_word_cnt, m_frame_cnt, m_last_line, m_last_word);
            end
            checks++; if ({err_line_len, err_frame_len, err_proto, locked} !== {m_el, m_ef, m_ep, m_clean >= LOCK}) begin
                errors++; $display("FAIL rand%0d.flags got=%b exp=%b", k, {err_line_len, err_frame_len, err_proto, locked}, {m_el, m_ef, m_ep, m_clean >= LOCK});
            end
            checks++; if (fps !== 8'(m_fps)) begin errors++; $display("FAIL rand%0d.fps got=%0d exp=%0d", k, fps, m_fps); end
        end
    endtask

    task automatic test_reset_midframe();
        cyc(1, 0, 0);
        cyc(1, 1, 0);
        cyc(1, 1, 1);
        cyc(1, 1, 1);
        reset = 1;
        cyc(1, 1, 1);
        model_reset();
        checks++; if (frame_cnt !== '0 || last_word_cnt !== '0 || locked !== 1'b0) begin errors++; $display("FAIL midreset.cleared got=%0d/%0d/%b exp=0/0/0", frame_cnt, last_word_cnt, locked); end
        reset = 0;
        cyc(0, 0, 0);
        send_frame(LPF, -1, 0, 0, 0);
        checks++; if (frame_cnt !== 16'd1 || last_line_cnt !== 16'd3 || last_word_cnt !== 16'd4) begin errors++; $display("FAIL midreset.fresh got=%0d/%0d/%0d exp=1/3/4", frame_cnt, last_line_cnt, last_word_cnt); end
        checks++; if ({err_line_len, err_frame_len, err_proto, locked} !== 4'b0000) begin errors++; $display("FAIL midreset.flags got=%b exp=0000", {err_line_len, err_frame_len, err_proto, locked}); end
    endtask

    initial begin
        reset = 1; in_frame = 0; in_line = 0; dat_vld = 0; sec_tick = 0; clr_err = 0;
        dbg_sel = 0; pend_tick = 0; pend_clr = 0;
        model_reset();
        test_reset();
        test_good_stream();
        test_short_line();
        test_protocol();
        test_combined_fall();
        test_fps();
        test_debug();
        test_random();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

endmodule
